// File: rtl/axi_ddr_tc_pkg.sv
// Shared types and helpers for the AXI DDR traffic checker.
// Holds the sequencer state encoding, LFSR taps, AXI response codes and
// the beat address arithmetic used by both the write and the read phase.
package axi_ddr_tc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CAL,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } tc_state_e;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Byte address of beat `beat` inside burst `idx` of the test region
    function automatic logic [63:0] beat_addr(
        input logic [63:0] base,
        input logic [31:0] idx,
        input logic [31:0] beat,
        input logic [31:0] burst_len,
        input logic [31:0] bytes_per_beat
    );
        logic [63:0] beat_num;
        beat_num = 64'(idx) * 64'(burst_len) + 64'(beat);
        return base + beat_num * 64'(bytes_per_beat);
    endfunction

endpackage

// File: rtl/tc_pattern_gen.sv
// Test pattern source: one DataWidth word per cycle, either the beat address
// folded into every 32-bit lane or a Galois LFSR stepped once per lane.
// Used once for write data and once for the read expectation.
module tc_pattern_gen
    import axi_ddr_tc_pkg::*;
#(
    parameter int DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 load_i,
    input  logic                 advance_i,
    input  logic                 mode_i,
    input  logic [31:0]          seed_i,
    input  logic [31:0]          addr_lo_i,
    output logic [DataWidth-1:0] data_o
);

    localparam int Lanes = DataWidth / 32;

    logic [31:0] lfsr_q, lfsr_d;

    // Build every lane of the current word and the LFSR state that follows it
    always_comb begin
        logic [31:0] s;
        s      = lfsr_q;
        data_o = '0;
        for (int k = 0; k < Lanes; k++) begin
            data_o[k*32 +: 32] = mode_i ? s : (addr_lo_i ^ 32'(k));
            s = lfsr_next(s);
        end
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (advance_i) begin
            lfsr_d = s;
        end
    end

    // LFSR state is always loaded before use, so it carries no reset
    always_ff @(posedge clk_i) begin
        lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/axi_ddr_traffic_checker.sv
// AXI4 DDR traffic generator/checker: writes a pattern over the test region,
// reads it back and counts mismatches and error responses (saturating).
// Optional first-mismatch capture: define AXI_DDR_TRAFFIC_CHECKER_ERRLOG_EN.
module axi_ddr_traffic_checker
    import axi_ddr_tc_pkg::*;
#(
    parameter int          AddrWidth   = 64,
    parameter int          DataWidth   = 64,
    parameter int          BurstLen    = 16,
    parameter int          NumBursts   = 64,
    parameter logic [63:0] BaseAddr    = 64'h8000_0000,
    parameter logic [31:0] Seed        = 32'hACE1_2468,
    parameter int          ErrCntWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic                     calib_done_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [ErrCntWidth-1:0]   err_cnt_o,
    output logic [AddrWidth-1:0]     aw_addr_o,
    output logic [7:0]               aw_len_o,
    output logic                     aw_valid_o,
    input  logic                     aw_ready_i,
    output logic [DataWidth-1:0]     w_data_o,
    output logic [DataWidth/8-1:0]   w_strb_o,
    output logic                     w_last_o,
    output logic                     w_valid_o,
    input  logic                     w_ready_i,
    input  logic [1:0]               b_resp_i,
    input  logic                     b_valid_i,
    output logic                     b_ready_o,
    output logic [AddrWidth-1:0]     ar_addr_o,
    output logic [7:0]               ar_len_o,
    output logic                     ar_valid_o,
    input  logic                     ar_ready_i,
    input  logic [DataWidth-1:0]     r_data_i,
    input  logic [1:0]               r_resp_i,
    input  logic                     r_last_i,
    input  logic                     r_valid_i,
    output logic                     r_ready_o
`ifdef AXI_DDR_TRAFFIC_CHECKER_ERRLOG_EN
    ,
    output logic [AddrWidth-1:0]     first_err_addr_o,
    output logic [DataWidth-1:0]     first_err_exp_o,
    output logic [DataWidth-1:0]     first_err_got_o
`endif
);

    localparam int BytesPerBeat = DataWidth / 8;
    localparam int IdxW  = (NumBursts > 1) ? $clog2(NumBursts) : 1;
    localparam int BeatW = (BurstLen > 1) ? $clog2(BurstLen) : 1;
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumBursts - 1);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BurstLen - 1);

    function automatic logic [ErrCntWidth-1:0] sat_inc(input logic [ErrCntWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    tc_state_e              state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [BeatW-1:0]       beat_q, beat_d;
    logic                   mode_q, mode_d;
    logic                   done_q, done_d;
    logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

    logic                   wgen_load, wgen_adv, rgen_load, rgen_adv;
    logic                   data_err, beat_err;
    logic [31:0]            cur_addr_lo;
    logic [AddrWidth-1:0]   burst_addr;
    logic [DataWidth-1:0]   wr_word, rd_word;

    assign cur_addr_lo = 32'(beat_addr(BaseAddr, 32'(idx_q), 32'(beat_q),
                                       32'(BurstLen), 32'(BytesPerBeat)));
    assign burst_addr  = AddrWidth'(beat_addr(BaseAddr, 32'(idx_q), 32'd0,
                                              32'(BurstLen), 32'(BytesPerBeat)));

    assign aw_addr_o = burst_addr;
    assign ar_addr_o = burst_addr;
    assign aw_len_o  = 8'(BurstLen - 1);
    assign ar_len_o  = 8'(BurstLen - 1);
    assign w_data_o  = wr_word;
    assign w_strb_o  = '1;
    assign w_last_o  = (beat_q == LastBeat);
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;
    assign err_cnt_o = err_cnt_q;
    assign error_o   = |err_cnt_q;

    tc_pattern_gen #(.DataWidth(DataWidth)) u_wr_gen (
        .clk_i    (clk_i),
        .load_i   (wgen_load),
        .advance_i(wgen_adv),
        .mode_i   (mode_q),
        .seed_i   (Seed),
        .addr_lo_i(cur_addr_lo),
        .data_o   (wr_word)
    );

    tc_pattern_gen #(.DataWidth(DataWidth)) u_rd_gen (
        .clk_i    (clk_i),
        .load_i   (rgen_load),
        .advance_i(rgen_adv),
        .mode_i   (mode_q),
        .seed_i   (Seed),
        .addr_lo_i(cur_addr_lo),
        .data_o   (rd_word)
    );

    // Sequencer: next state, burst/beat counters, handshakes and error counting
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        beat_d     = beat_q;
        mode_d     = mode_q;
        done_d     = done_q;
        err_cnt_d  = err_cnt_q;
        wgen_load  = 1'b0;
        wgen_adv   = 1'b0;
        rgen_load  = 1'b0;
        rgen_adv   = 1'b0;
        data_err   = 1'b0;
        beat_err   = 1'b0;
        aw_valid_o = 1'b0;
        w_valid_o  = 1'b0;
        b_ready_o  = 1'b0;
        ar_valid_o = 1'b0;
        r_ready_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    done_d    = 1'b0;
                    err_cnt_d = '0;
                    mode_d    = mode_i;
                    state_d   = ST_WAIT_CAL;
                end
            end
            ST_WAIT_CAL: begin
                if (calib_done_i) begin
                    idx_d     = '0;
                    beat_d    = '0;
                    wgen_load = 1'b1;
                    state_d   = ST_WR_ADDR;
                end
            end
            ST_WR_ADDR: begin
                aw_valid_o = 1'b1;
                if (aw_ready_i) state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                w_valid_o = 1'b1;
                if (w_ready_i) begin
                    wgen_adv = 1'b1;
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = ST_WR_RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_WR_RESP: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    if (b_resp_i != AXI_RESP_OKAY) err_cnt_d = sat_inc(err_cnt_q);
                    if (idx_q == LastIdx) begin
                        idx_d     = '0;
                        rgen_load = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_WR_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                ar_valid_o = 1'b1;
                if (ar_ready_i) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                r_ready_o = 1'b1;
                if (r_valid_i) begin
                    rgen_adv = 1'b1;
                    data_err = (r_data_i != rd_word);
                    // Several faults on one beat still count as a single error
                    beat_err = data_err || (r_resp_i != AXI_RESP_OKAY) ||
                               (r_last_i != (beat_q == LastBeat));
                    if (beat_err) err_cnt_d = sat_inc(err_cnt_q);
                    if (beat_q == LastBeat) begin
                        beat_d = '0;
                        if (idx_q == LastIdx) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_RD_ADDR;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer and status registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            beat_q    <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            beat_q    <= beat_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef AXI_DDR_TRAFFIC_CHECKER_ERRLOG_EN
    logic                 first_err_vld_q, first_err_vld_d;
    logic [AddrWidth-1:0] first_err_addr_q, first_err_addr_d;
    logic [DataWidth-1:0] first_err_exp_q, first_err_exp_d;
    logic [DataWidth-1:0] first_err_got_q, first_err_got_d;

    // Keep the first read-data mismatch of a pass; a new start clears it
    always_comb begin
        first_err_vld_d  = first_err_vld_q;
        first_err_addr_d = first_err_addr_q;
        first_err_exp_d  = first_err_exp_q;
        first_err_got_d  = first_err_got_q;
        if (state_q == ST_IDLE && start_i) begin
            first_err_vld_d  = 1'b0;
            first_err_addr_d = '0;
            first_err_exp_d  = '0;
            first_err_got_d  = '0;
        end else if (data_err && !first_err_vld_q) begin
            first_err_vld_d  = 1'b1;
            first_err_addr_d = AddrWidth'(beat_addr(BaseAddr, 32'(idx_q), 32'(beat_q),
                                                    32'(BurstLen), 32'(BytesPerBeat)));
            first_err_exp_d  = rd_word;
            first_err_got_d  = r_data_i;
        end
    end

    // First-error capture registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_err_vld_q  <= 1'b0;
            first_err_addr_q <= '0;
            first_err_exp_q  <= '0;
            first_err_got_q  <= '0;
        end else begin
            first_err_vld_q  <= first_err_vld_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_exp_q  <= first_err_exp_d;
            first_err_got_q  <= first_err_got_d;
        end
    end

    assign first_err_addr_o = first_err_addr_q;
    assign first_err_exp_o  = first_err_exp_q;
    assign first_err_got_o  = first_err_got_q;
`endif

endmodule
